store_trace_buffer: RTL

- Passive observer on the data-memory side of mips_single_cycle.
- Sits between the CPU data port and the data memory and consumes the same address/write-data/strobe signals the memory sees.
- Captures every store (address, data) into a FIFO that a bench or debug reader drains with a valid/ready handshake.
- Keeps saturating store/load counters and latches the first store to a configurable watch address, which serves as the program-completion flag.

---
 rtl/store_trace_buffer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/store_trace_buffer.sv
// store_trace_buffer
//
// Passive observer on the data-memory side of mips_single_cycle. It sees the
// same address / write-data / strobe signals as the data memory. It records
// every store in a FIFO, which a bench or debug reader drains through a
// valid/ready handshake. It also keeps saturating store and load counters.
// The first store to WATCH_ADDR latches watch_hit, which marks program
// completion. The block only observes: it drives nothing back toward the CPU
// or the memory.
//
// Ports
//   clk          rising-edge clock (CPU clock)
//   rst          synchronous active-high reset
//   data_adr     CPU data address
//   data_in      CPU store data (memory write data)
//   mem_read     CPU load strobe
//   mem_write    CPU store strobe
//   trace_ready  reader accepts the head entry
//   trace_valid  FIFO non-empty
//   trace_adr    head entry address (0 when empty)
//   trace_data   head entry data (0 when empty)
//   fill         current occupancy, 0..DEPTH
//   overflow     sticky: a store was dropped because the FIFO was full
//   proto_err    sticky: mem_read and mem_write were high on the same edge
//   store_cnt    stores observed, saturating
//   load_cnt     loads observed, saturating
//   watch_hit    sticky: a store to WATCH_ADDR occurred
//   watch_data   data of the most recent store to WATCH_ADDR

module store_trace_buffer #(
  parameter int          DEPTH      = 16,
  parameter int          CNT_W      = 16,
  parameter logic [31:0] WATCH_ADDR = 32'h0000_07D0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                data_adr,
  input  logic [31:0]                data_in,
  input  logic                       mem_read,
  input  logic                       mem_write,
  input  logic                       trace_ready,
  output logic                       trace_valid,
  output logic [31:0]                trace_adr,
  output logic [31:0]                trace_data,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       overflow,
  output logic                       proto_err,
  output logic [CNT_W-1:0]           store_cnt,
  output logic [CNT_W-1:0]           load_cnt,
  output logic                       watch_hit,
  output logic [31:0]                watch_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] FULL_FILL = FW'(DEPTH);

  logic [31:0]   adr_mem  [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;
  logic watch_match;

  assign empty = (fill == '0);
  assign full  = (fill == FULL_FILL);

  // Popping on an empty FIFO is impossible, so trace_ready is ignored there.
  // This also means a push into an empty FIFO is never popped on the same edge.
  assign pop  = !empty && trace_ready;

  // A full FIFO still accepts a store when the head leaves on the same edge.
  assign push = mem_write && (!full || pop);
  assign drop = mem_write && full && !pop;

  assign watch_match = mem_write && (data_adr == WATCH_ADDR);

  assign trace_valid = !empty;
  assign trace_adr   = empty ? 32'h0 : adr_mem[rd_ptr];
  assign trace_data  = empty ? 32'h0 : data_mem[rd_ptr];

  // The storage array has no reset. Stale entries are never visible, because
  // the head outputs are forced to 0 while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      adr_mem[wr_ptr]  <= data_adr;
      data_mem[wr_ptr] <= data_in;
    end
  end

  // Pointers wrap naturally modulo DEPTH, since DEPTH is a power of two.
  // fill tracks writes minus reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fill <= fill + FW'(1);
        2'b01:   fill <= fill - FW'(1);
        default: fill <= fill;
      endcase
    end
  end

  // Every edge with mem_write counts as a store request, including dropped
  // stores. A combined read+write edge counts as a store only, and it raises
  // proto_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      store_cnt  <= '0;
      load_cnt   <= '0;
      overflow   <= 1'b0;
      proto_err  <= 1'b0;
      watch_hit  <= 1'b0;
      watch_data <= 32'h0;
    end else begin
      if (mem_write && (store_cnt != '1))
        store_cnt <= store_cnt + CNT_W'(1);
      if (mem_read && !mem_write && (load_cnt != '1))
        load_cnt <= load_cnt + CNT_W'(1);
      if (drop)
        overflow <= 1'b1;
      if (mem_read && mem_write)
        proto_err <= 1'b1;
      if (watch_match) begin
        watch_hit  <= 1'b1;
        watch_data <= data_in;
      end
    end
  end

endmodule
